// File: rtl/dbi_ac_if.sv
// Valid/ready bus between the inversion-decision logic, the AC-DBI encoder stage and the sink.
// The master modport is the environment side: it drives upstream words and the sink's ready.
interface dbi_ac_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_dbi;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_dbi
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_dbi
  );
endinterface

// File: rtl/dbi_ac_encoder.sv
// Registered AC-DBI encoder: sends each word or its complement, whichever toggles fewer bus
// lines (DBI line included), and keeps a saturating count of the toggles it causes.
module dbi_ac_lane (
  input  logic d_i,
  input  logic b_i,
  input  logic inv_i,
  output logic diff_o,
  output logic nxt_o,
  output logic tog_o
);
  assign diff_o = d_i ^ b_i;
  assign nxt_o  = d_i ^ inv_i;
  assign tog_o  = nxt_o ^ b_i;
endmodule

module dbi_ac_encoder #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dbi_en,
  input  logic             cnt_clr,
  dbi_ac_if.slave          bus,
  output logic [CNT_W-1:0] toggle_cnt
);
  // Wide enough for 0..W+1 toggles.
  localparam int PW = $clog2(W + 2);

  logic [W-1:0]     data_q, data_d, diff, tog;
  logic             dbi_q, vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [CNT_W:0]   sum;
  logic [PW-1:0]    t, cost_n, cost_i, tcnt;
  logic             load, inv;

  function automatic logic [PW-1:0] popcnt(input logic [W-1:0] v);
    popcnt = '0;
    for (int i = 0; i < W; i++) popcnt = popcnt + PW'(v[i]);
  endfunction

  for (genvar g = 0; g < W; g++) begin : g_lane
    dbi_ac_lane u_lane (
      .d_i   (bus.in_data[g]),
      .b_i   (data_q[g]),
      .inv_i (inv),
      .diff_o(diff[g]),
      .nxt_o (data_d[g]),
      .tog_o (tog[g])
    );
  end

  assign bus.in_ready = !vld_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;

  always_comb begin
    t      = popcnt(diff);
    cost_n = t + PW'(dbi_q);
    cost_i = PW'(W) - t + PW'(!dbi_q);
    // Ties keep the DBI line where it is so it does not toggle.
    inv    = dbi_en && ((cost_i < cost_n) || ((cost_i == cost_n) && dbi_q));
    tcnt   = popcnt(tog) + PW'(inv ^ dbi_q);
  end

  always_comb begin
    vld_d    = load ? 1'b1 : (bus.out_ready ? 1'b0 : vld_q);
    cnt_base = cnt_clr ? '0 : cnt_q;
    sum      = {1'b0, cnt_base} + (CNT_W+1)'(tcnt);
    cnt_d    = cnt_q;
    if (load)         cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    else if (cnt_clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      dbi_q  <= 1'b0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      if (load) begin
        data_q <= data_d;
        dbi_q  <= inv;
      end
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_dbi   = dbi_q;
  assign toggle_cnt    = cnt_q;
endmodule

// File: tb/tb_dbi_ac_encoder.sv
// Bench for dbi_ac_encoder: directed words with hand-computed bus/DBI/counter values, checked by
// per-instance monitors against queues filled by the driver.
module tb_dbi_ac_encoder;
  logic clk = 0, rst_n = 0, dbi_en = 0, cnt_clr = 0;
  always #5 clk = ~clk;

  dbi_ac_if #(.W(8)) if8();
  dbi_ac_if #(.W(9)) if9();
  dbi_ac_if #(.W(8)) if4();
  logic [15:0] cnt8, cnt9;
  logic [3:0]  cnt4;

  dbi_ac_encoder #(.W(8), .CNT_W(16)) u8 (.clk(clk), .rst_n(rst_n), .dbi_en(dbi_en),
    .cnt_clr(cnt_clr), .bus(if8), .toggle_cnt(cnt8));
  dbi_ac_encoder #(.W(9), .CNT_W(16)) u9 (.clk(clk), .rst_n(rst_n), .dbi_en(dbi_en),
    .cnt_clr(cnt_clr), .bus(if9), .toggle_cnt(cnt9));
  dbi_ac_encoder #(.W(8), .CNT_W(4))  u4 (.clk(clk), .rst_n(rst_n), .dbi_en(dbi_en),
    .cnt_clr(cnt_clr), .bus(if4), .toggle_cnt(cnt4));

  typedef struct {
    logic [31:0] d;
    logic        dbi;
    logic [15:0] c;
  } exp_t;
  exp_t q8[$], q9[$], q4[$];
  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && if8.out_valid && if8.out_ready) begin : m8
    exp_t e;
    if (q8.size() == 0) begin
      tests++; fails++;
      $display("FAIL u8 unexpected word: got %0h expected none", if8.out_data);
    end else begin
      e = q8.pop_front();
      chk("u8 data", 32'(if8.out_data), e.d);
      chk("u8 dbi",  32'(if8.out_dbi),  32'(e.dbi));
      chk("u8 cnt",  32'(cnt8),         32'(e.c));
    end
  end

  always @(negedge clk) if (rst_n && if9.out_valid && if9.out_ready) begin : m9
    exp_t e;
    if (q9.size() == 0) begin
      tests++; fails++;
      $display("FAIL u9 unexpected word: got %0h expected none", if9.out_data);
    end else begin
      e = q9.pop_front();
      chk("u9 data", 32'(if9.out_data), e.d);
      chk("u9 dbi",  32'(if9.out_dbi),  32'(e.dbi));
      chk("u9 cnt",  32'(cnt9),         32'(e.c));
    end
  end

  always @(negedge clk) if (rst_n && if4.out_valid && if4.out_ready) begin : m4
    exp_t e;
    if (q4.size() == 0) begin
      tests++; fails++;
      $display("FAIL u4 unexpected word: got %0h expected none", if4.out_data);
    end else begin
      e = q4.pop_front();
      chk("u4 data", 32'(if4.out_data), e.d);
      chk("u4 dbi",  32'(if4.out_dbi),  32'(e.dbi));
      chk("u4 cnt",  32'(cnt4),         32'(e.c));
    end
  end

  task automatic drive(input int sel, input logic v, input logic [31:0] d);
    case (sel)
      8:       begin if8.in_valid = v; if8.in_data = d[7:0]; end
      9:       begin if9.in_valid = v; if9.in_data = d[8:0]; end
      default: begin if4.in_valid = v; if4.in_data = d[7:0]; end
    endcase
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      8:       rdy = if8.in_ready;
      9:       rdy = if9.in_ready;
      default: rdy = if4.in_ready;
    endcase
  endfunction

  task automatic send(input int sel, input logic [31:0] din, input logic en, input logic clr,
                      input logic [31:0] ed, input logic edbi, input logic [15:0] ec,
                      output int stalls);
    exp_t e;
    logic r;
    e.d = ed; e.dbi = edbi; e.c = ec;
    case (sel)
      8:       q8.push_back(e);
      9:       q9.push_back(e);
      default: q4.push_back(e);
    endcase
    drive(sel, 1'b1, din);
    dbi_en = en; cnt_clr = clr; stalls = 0;
    forever begin
      @(negedge clk); r = rdy(sel);
      @(posedge clk); #1;
      if (r) break;
      stalls++;
      if (stalls > 100) begin
        tests++; fails++;
        $display("FAIL handshake timeout: got no in_ready on u%0d expected ready", sel);
        break;
      end
    end
    drive(sel, 1'b0, din);
    cnt_clr = 0;
  endtask

  task automatic tx(input int sel, input logic [31:0] din, input logic en,
                    input logic [31:0] ed, input logic edbi, input logic [15:0] ec);
    int s;
    send(sel, din, en, 1'b0, ed, edbi, ec, s);
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() + q9.size() + q4.size()) != 0 && n < 50) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    chk("drain pending", 32'(q8.size() + q9.size() + q4.size()), 32'd0);
  endtask

  task automatic flush();
    q8.delete(); q9.delete(); q4.delete();
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive(8, 1'b0, 0); drive(9, 1'b0, 0); drive(4, 1'b0, 0);
    flush();
    #12;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    int s;
    if8.out_ready = 1; if9.out_ready = 1; if4.out_ready = 1;
    drive(8, 1'b0, 0); drive(9, 1'b0, 0); drive(4, 1'b0, 0);
    #12;
    chk("rst out_valid", 32'(if8.out_valid), 0);
    chk("rst out_data",  32'(if8.out_data),  0);
    chk("rst out_dbi",   32'(if8.out_dbi),   0);
    chk("rst cnt",       32'(cnt8),          0);
    chk("rst in_ready",  32'(if8.in_ready),  1);
    chk("rst u9 valid",  32'(if9.out_valid), 0);
    chk("rst u4 cnt",    32'(cnt4),          0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Main stream, back to back.
    tx(8, 32'hFF, 1, 32'h00, 1, 1);
    tx(8, 32'hF0, 1, 32'h0F, 1, 5);
    tx(8, 32'h0F, 1, 32'h0F, 0, 6);
    tx(8, 32'h1F, 1, 32'h1F, 0, 7);
    tx(8, 32'h00, 0, 32'h00, 0, 12);
    tx(8, 32'hFF, 0, 32'hFF, 0, 20);
    tx(8, 32'h00, 1, 32'hFF, 1, 21);
    drain();
    chk("idle out_valid cleared", 32'(if8.out_valid), 0);

    // Backpressure: three stalled cycles, then consume and load in the same edge.
    if8.out_ready = 0;
    tx(8, 32'h3C, 1, 32'hC3, 1, 25);
    fork
      send(8, 32'h01, 1, 1'b0, 32'h01, 0, 29, s);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall in_ready",  32'(if8.in_ready),  0);
          chk("stall out_valid", 32'(if8.out_valid), 1);
          chk("stall out_data",  32'(if8.out_data),  32'hC3);
          chk("stall out_dbi",   32'(if8.out_dbi),   1);
        end
        @(posedge clk); #1;
        if8.out_ready = 1;
      end
    join
    chk("stall cycles", 32'(s), 3);
    send(8, 32'h81, 1, 1'b0, 32'h81, 0, 30, s);
    chk("no bubble", 32'(s), 0);
    drain();

    // Odd width ties.
    do_reset();
    tx(9, 32'h00F, 1, 32'h00F, 0, 4);
    tx(9, 32'h1FF, 1, 32'h1FF, 0, 9);
    drain();
    do_reset();
    tx(9, 32'h1FF, 1, 32'h000, 1, 1);
    tx(9, 32'h00F, 1, 32'h1F0, 1, 6);
    drain();

    // Saturation and clear.
    tx(4, 32'hFF, 0, 32'hFF, 0, 8);
    tx(4, 32'h00, 0, 32'h00, 0, 15);
    tx(4, 32'hFF, 0, 32'hFF, 0, 15);
    tx(4, 32'h00, 0, 32'h00, 0, 15);
    send(4, 32'hFF, 0, 1'b1, 32'hFF, 0, 8, s);
    drain();
    cnt_clr = 1;
    @(posedge clk); #1;
    cnt_clr = 0;
    chk("idle clr cnt", 32'(cnt4), 0);

    // Asynchronous reset with a word held on the bus.
    if8.out_ready = 0;
    tx(8, 32'hAA, 1, 32'hAA, 0, 4);
    chk("pre-rst out_valid", 32'(if8.out_valid), 1);
    chk("pre-rst out_data",  32'(if8.out_data),  32'hAA);
    #2 rst_n = 0;
    #1;
    chk("mid-rst out_valid", 32'(if8.out_valid), 0);
    chk("mid-rst out_data",  32'(if8.out_data),  0);
    chk("mid-rst out_dbi",   32'(if8.out_dbi),   0);
    chk("mid-rst cnt",       32'(cnt8),          0);
    chk("mid-rst in_ready",  32'(if8.in_ready),  1);
    flush();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    if8.out_ready = 1;
    tx(8, 32'hFF, 1, 32'h00, 1, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dbi_ac_encoder.md
Name: dbi_ac_encoder

Overview:
- Registered AC data-bus-inversion encoder stage. It sits directly downstream of the combinational inversion-decision logic and drives the physical bus.
- Accepts one data word per valid/ready handshake. It compares the word against the word currently on the bus, including the DBI line, and transmits either the word or its complement, whichever causes fewer line toggles.
- Maintains a saturating toggle counter used for power characterisation.

Parameters:
- W, 8, data bus width in bits (legal range 2..32)
- CNT_W, 16, width of the toggle statistics counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- dbi_en  input  1  1 = inversion allowed; 0 = bypass, dbi forced 0
- in_valid  input  1  upstream word valid
- in_ready  output  1  stage can accept a word this cycle
- in_data  input  W  upstream data word
- out_valid  output  1  bus word valid
- out_ready  input  1  sink consumes the bus word this cycle
- out_data  output  W  encoded bus data (registered)
- out_dbi  output  1  DBI line (registered); 1 = out_data is inverted
- cnt_clr  input  1  synchronous clear of toggle counter
- toggle_cnt  output  CNT_W  accumulated bus-line toggles, saturating

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_data=0, out_dbi=0, toggle_cnt=0. in_ready is combinational and therefore 1 after reset.
- Bus state: the out_data/out_dbi registers are the bus. They hold their value after a handshake and are never cleared.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - A load occurs on in_valid && in_ready.
  - Latency is 1 cycle: the word appears on out_* the cycle after it is accepted.
  - out_valid is set on a load. It is cleared on out_ready when no load occurs in the same cycle.
  - Simultaneous consume and load in one cycle: full throughput, no bubble.
- Decision at load, with B = out_data and b = out_dbi as they stand before the load:
  - T = popcount(in_data ^ B).
  - Non-inverted cost = T + (b != 0).
  - Inverted cost = (W - T) + (b != 1).
  - Choose the lower cost. On a tie (possible only for odd W), choose the candidate whose dbi equals b.
  - Inverted candidate: out_data = ~in_data, out_dbi = 1. Non-inverted: out_data = in_data, out_dbi = 0.
- dbi_en=0: always take the non-inverted candidate (out_dbi=0). dbi_en is sampled at the load cycle only.
- Stall: with out_valid=1 and out_ready=0, all outputs hold and in_data is ignored.
- Toggle counter:
  - On each load, add popcount({new out_data,new out_dbi} ^ {B,b}), i.e. 0..W+1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr without a load sets the counter to 0. cnt_clr with a load sets it to that load's toggle count.
  - Idle cycles add nothing.
- Reset mid-operation: the in-flight word is dropped, all state returns to reset values, and the next load compares against bus 0/dbi 0.
- No combinational path from in_data to out_*. in_ready depends only on out_valid and out_ready.

Test Plan:
- Reset, then in 0xFF (dbi_en=1, bus 0x00/0) -> next cycle out_data=0x00, out_dbi=1, toggle_cnt=1.
- Follow with 0xF0 -> out 0x0F/1, cnt=5. Then 0x0F -> out 0x0F/0, cnt=6. Then 0x1F from bus 0x0F/0 -> out 0x1F/0, cnt=7.
- dbi_en=0, bus 0x00/0, in 0xFF -> out 0xFF/0, cnt += 8. Then dbi_en=1, in 0x00 -> out 0xFF/1, cnt += 1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* held, word not lost. Release -> next word loads the same cycle, no bubble, sequence order preserved.
- W=9 tie: bus 0x000/0, in 0x00F (T=4: costs 4 vs 6) -> non-inverted. Then bus 0x000/1, in 0x00F -> costs 5/5 tie -> keep dbi=1: out 0x1F0/1.
- Saturation/clear: CNT_W=4, stream alternating 0x00/0xFF with dbi_en=0 -> counter stops at 15. Assert cnt_clr with a concurrent 0x00->0xFF load -> cnt=8. Pulse rst_n low while out_valid=1 -> all outputs 0 immediately.
